uart_word_framer: RTL and testbench
===================================

Name: uart_word_framer

Overview:
- Sits directly downstream of the UART byte receiver and upstream of the seven-segment display register.
- Replaces ad-hoc byte pairing, which drifts permanently after one lost byte, with a framed, checksummed, self-resynchronising word receiver.
- Receives bytes via data/ready from the baud-domain receiver, hunts for a sync byte, assembles a 16-bit little-endian word, verifies a checksum and emits a one-cycle word strobe in the clk domain.

Parameters:
- SYNC_BYTE, 8'hA5: frame start marker.
- TIMEOUT_CYCLES, 5_000_000: clk cycles allowed between bytes inside a frame (100 ms at 50 MHz).
- TO_W, 23: timeout counter width. Must satisfy 2^TO_W > TIMEOUT_CYCLES.

Ports:
- clk  input  1  system clock, 50 MHz.
- rst_n  input  1  asynchronous active-low reset.
- rx_data  input  8  received byte from the UART receiver. Stable while rx_ready is high.
- rx_ready  input  1  byte-ready level/pulse from the receiver, generated in the baud domain and asynchronous to clk.
- word  output  16  last good word, {hi, lo}.
- word_valid  output  1  one-cycle strobe: word just updated.
- chk_err  output  1  one-cycle strobe: frame rejected on checksum.
- timeout  output  1  one-cycle strobe: frame abandoned on inter-byte timeout.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values:
  - word = 16'h0000; word_valid, chk_err, timeout, busy = 0.
  - state = IDLE; synchroniser flops = 0; timeout counter = 0.
- Input sync: rx_ready passes through two flops (s1, s2) and a third flop s3.
  - byte_stb = s2 & ~s3. This is exactly one clk per rising edge of rx_ready.
  - rx_data is registered into byte_q on byte_stb.
  - Latency: byte_stb fires 3 clk edges after rx_ready rises.
- FSM states: IDLE, LO, HI, CHK.
  - IDLE: on byte_stb with rx_data == SYNC_BYTE -> LO. Any other byte is ignored and the FSM stays in IDLE.
  - LO: on byte_stb, lo <= rx_data -> HI. A byte equal to SYNC_BYTE is data here; there is no re-sync mid-frame.
  - HI: on byte_stb, hi <= rx_data -> CHK.
  - CHK: on byte_stb, compare rx_data against (lo + hi) mod 256, then -> IDLE.
    - Match: word <= {hi, lo} and word_valid = 1 for the next cycle.
    - Mismatch: chk_err = 1 for the next cycle; word is unchanged.
- Output latency: word and word_valid update on the clk edge after the checksum byte's byte_stb.
- Timeout counter:
  - Cleared in IDLE and on every byte_stb.
  - Otherwise increments each clk.
  - When it reaches TIMEOUT_CYCLES-1 with no byte_stb that cycle: state -> IDLE and timeout = 1 for one cycle.
  - If byte_stb and the expiry coincide, byte_stb wins: the byte is processed and there is no timeout.
- The counter must not wrap. It saturates by construction because expiry forces IDLE.
- busy is registered and equals (state != IDLE) as of the current state.
- word_valid, chk_err and timeout are mutually exclusive.
- Reset asserted mid-frame: immediate return to IDLE with all reset values. No strobe is emitted on release.
- rx_ready held high across several clk cycles yields exactly one byte_stb.
- Back-to-back bytes spaced 4 or more clk cycles apart must all be accepted.

Decomposition:
- Shared package constants: FSM state encoding (2-bit: IDLE=0, LO=1, HI=2, CHK=3), default SYNC_BYTE, default TIMEOUT_CYCLES for 50 MHz.
- One natural sub-module: sync_edge. It holds the 2-flop synchroniser plus rising-edge detector and outputs byte_stb. It is reusable for button and other async strobes.
- Checksum and FSM stay in uart_word_framer.

Test Plan:
- Bytes A5, 34, 12, 46 -> word = 16'h1234, word_valid high one cycle, 4 clk after the 4th rx_ready rise; busy returns low.
- Bytes A5, 34, 12, 47 -> chk_err one cycle; word keeps its previous value (16'h1234 or 0 after reset).
- Junk 00, 7F, then A5, A5, FF, A4 -> junk ignored; 2nd A5 taken as lo; word = 16'hFFA5 valid.
- Bytes A5, 34, then idle for TIMEOUT_CYCLES (use TIMEOUT_CYCLES=100 in sim) -> timeout pulse at cycle 100, busy low; a following A5, 01, 02, 03 gives word = 16'h0201.
- rst_n pulsed low after A5, 34 -> all outputs zero, state IDLE; subsequent 12, 46 ignored with no strobes.
- rx_ready held high 20 clk per byte, valid frame A5, FF, FF, FE -> exactly one byte_stb per byte; word = 16'hFFFF valid once.

Source files
------------

// File: rtl/uart_word_framer_pkg.sv
// uart_word_framer_pkg
// Shared types and constants for the UART word framer slice.
//   state_e    : framer FSM state encoding (IDLE=0, LO=1, HI=2, CHK=3)
//   byte_t     : one received UART byte
//   DEFAULT_*  : default sync marker and 100 ms inter-byte timeout at 50 MHz
//   checksum8  : frame checksum, (lo + hi) mod 256
package uart_word_framer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2,
        ST_CHK  = 2'd3
    } state_e;

    typedef logic [7:0] byte_t;

    localparam byte_t DEFAULT_SYNC_BYTE      = 8'hA5;
    localparam int    DEFAULT_TIMEOUT_CYCLES = 5_000_000;
    localparam int    DEFAULT_TO_W           = 23;

    // Eight-bit addition wraps naturally, giving the mod-256 sum.
    function automatic byte_t checksum8(input byte_t lo, input byte_t hi);
        return lo + hi;
    endfunction

endpackage

// File: rtl/uart_word_framer_if.sv
// uart_word_framer_if
// Byte-in / word-out bundle between the UART receiver, the framer and the
// display register.
//   rx_data, rx_ready : byte and async byte-ready from the baud-domain receiver
//   word              : last good 16-bit word {hi, lo}
//   word_valid        : one-cycle strobe, word just updated
//   chk_err           : one-cycle strobe, frame rejected on checksum
//   timeout           : one-cycle strobe, frame abandoned on inter-byte timeout
//   busy              : framer is inside a frame
// master drives the bytes and observes results; slave is the framer.
interface uart_word_framer_if;
    import uart_word_framer_pkg::*;

    byte_t       rx_data;
    logic        rx_ready;
    logic [15:0] word;
    logic        word_valid;
    logic        chk_err;
    logic        timeout;
    logic        busy;

    modport master (
        output rx_data, rx_ready,
        input  word, word_valid, chk_err, timeout, busy
    );

    modport slave (
        input  rx_data, rx_ready,
        output word, word_valid, chk_err, timeout, busy
    );

endinterface

// File: rtl/uart_word_framer_sync_edge.sv
// uart_word_framer_sync_edge
// Two-flop synchroniser plus rising-edge detector for an asynchronous level
// or pulse. Emits exactly one clk-wide pulse per rising edge of async_i, no
// matter how long async_i stays high. Reusable for buttons and other strobes.
//   clk     : system clock
//   rst_n   : asynchronous active-low reset
//   async_i : asynchronous input
//   pulse_o : one-cycle pulse, high the cycle after the synchronised rise
module uart_word_framer_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic async_i,
    output logic pulse_o
);

    logic s1_q;
    logic s2_q;
    logic s3_q;

    // s1/s2 resolve metastability; s3 holds the previous synchronised value
    // so that a rise can be detected.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= async_i;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign pulse_o = s2_q & ~s3_q;

endmodule

// File: rtl/uart_word_framer.sv
// uart_word_framer
// Framed, checksummed, self-resynchronising word receiver. Hunts for
// SYNC_BYTE, then takes lo, hi and a checksum byte; a good frame updates
// word and strobes word_valid, a bad one strobes chk_err. A gap longer than
// TIMEOUT_CYCLES inside a frame abandons it and strobes timeout.
//   clk   : system clock (50 MHz)
//   rst_n : asynchronous active-low reset
//   bus   : slave side of uart_word_framer_if (bytes in, word and strobes out)
module uart_word_framer
    import uart_word_framer_pkg::*;
#(
    parameter byte_t SYNC_BYTE      = DEFAULT_SYNC_BYTE,
    parameter int    TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter int    TO_W           = DEFAULT_TO_W
) (
    input  logic                clk,
    input  logic                rst_n,
    uart_word_framer_if.slave   bus
);

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic        byte_stb;
    byte_t       byte_q;
    logic        byte_vld_q;

    state_e      state_q,      state_d;
    byte_t       lo_q,         lo_d;
    byte_t       hi_q,         hi_d;
    logic [15:0] word_q,       word_d;
    logic        word_valid_q, word_valid_d;
    logic        chk_err_q,    chk_err_d;
    logic        timeout_q,    timeout_d;
    logic        busy_q;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;

    uart_word_framer_sync_edge u_sync_edge (
        .clk     (clk),
        .rst_n   (rst_n),
        .async_i (bus.rx_ready),
        .pulse_o (byte_stb)
    );

    // Capture the byte on its strobe. The FSM works from this registered
    // copy and the delayed strobe so byte and strobe are always aligned.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_q     <= '0;
            byte_vld_q <= 1'b0;
        end else begin
            byte_vld_q <= byte_stb;
            if (byte_stb) begin
                byte_q <= bus.rx_data;
            end
        end
    end

    // State, frame fields, outputs and timeout counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            lo_q         <= '0;
            hi_q         <= '0;
            word_q       <= '0;
            word_valid_q <= 1'b0;
            chk_err_q    <= 1'b0;
            timeout_q    <= 1'b0;
            busy_q       <= 1'b0;
            to_cnt_q     <= '0;
        end else begin
            state_q      <= state_d;
            lo_q         <= lo_d;
            hi_q         <= hi_d;
            word_q       <= word_d;
            word_valid_q <= word_valid_d;
            chk_err_q    <= chk_err_d;
            timeout_q    <= timeout_d;
            busy_q       <= (state_d != ST_IDLE);
            to_cnt_q     <= to_cnt_d;
        end
    end

    // Frame FSM. A received byte always takes priority over timeout expiry,
    // and expiry forces IDLE, which clears the counter, so it never wraps.
    always_comb begin
        state_d      = state_q;
        lo_d         = lo_q;
        hi_d         = hi_q;
        word_d       = word_q;
        word_valid_d = 1'b0;
        chk_err_d    = 1'b0;
        timeout_d    = 1'b0;

        if (state_q == ST_IDLE || byte_vld_q) begin
            to_cnt_d = '0;
        end else begin
            to_cnt_d = to_cnt_q + TO_W'(1);
        end

        if (byte_vld_q) begin
            case (state_q)
                ST_IDLE: begin
                    if (byte_q == SYNC_BYTE) begin
                        state_d = ST_LO;
                    end
                end
                ST_LO: begin
                    lo_d    = byte_q;
                    state_d = ST_HI;
                end
                ST_HI: begin
                    hi_d    = byte_q;
                    state_d = ST_CHK;
                end
                ST_CHK: begin
                    state_d = ST_IDLE;
                    if (byte_q == checksum8(lo_q, hi_q)) begin
                        word_d       = {hi_q, lo_q};
                        word_valid_d = 1'b1;
                    end else begin
                        chk_err_d = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end else if (state_q != ST_IDLE && to_cnt_q == TO_LAST) begin
            state_d   = ST_IDLE;
            timeout_d = 1'b1;
            to_cnt_d  = '0;
        end
    end

    assign bus.word       = word_q;
    assign bus.word_valid = word_valid_q;
    assign bus.chk_err    = chk_err_q;
    assign bus.timeout    = timeout_q;
    assign bus.busy       = busy_q;

endmodule

// File: tb/tb_uart_word_framer.sv
// tb_uart_word_framer
// Directed frames followed by a random byte stream for uart_word_framer.
// Expected words and strobe counts come from a frame-level model: a byte
// queue that drops non-sync bytes and consumes complete four-byte frames.
module tb_uart_word_framer;
    import uart_word_framer_pkg::*;

    localparam int    TO_CYC = 100;
    localparam byte_t SYNC   = 8'hA5;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    uart_word_framer_if bus ();

    uart_word_framer #(
        .SYNC_BYTE      (SYNC),
        .TIMEOUT_CYCLES (TO_CYC),
        .TO_W           (23)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    int validCnt    = 0;
    int errCnt      = 0;
    int toCnt       = 0;
    int lastValidCyc = -1;
    int lastToCyc    = -1;
    int riseCyc      = 0;

    byte_t       modelQ[$];
    logic [15:0] modelWord = 16'h0000;
    int          expValid  = 0;
    int          expErr    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Strobe monitor: counts pulses, remembers when they happened, and
    // checks the three strobes never overlap.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.word_valid === 1'b1) begin
                validCnt++;
                lastValidCyc = cyc;
            end
            if (bus.chk_err === 1'b1) errCnt++;
            if (bus.timeout === 1'b1) begin
                toCnt++;
                lastToCyc = cyc;
            end
            checkOutput("strobe_exclusive",
                        32'($countones({bus.word_valid, bus.chk_err, bus.timeout}) <= 1), 32'd1);
        end
    end

    // Frame-level reference: drop bytes until a sync marker, then judge each
    // complete four-byte frame by its mod-256 checksum.
    task automatic modelFeed(input byte_t b);
        modelQ.push_back(b);
        while (modelQ.size() > 0) begin
            if (modelQ[0] != SYNC) begin
                void'(modelQ.pop_front());
                continue;
            end
            if (modelQ.size() < 4) break;
            if (((int'(modelQ[1]) + int'(modelQ[2])) % 256) == int'(modelQ[3])) begin
                modelWord = {modelQ[2], modelQ[1]};
                expValid++;
            end else begin
                expErr++;
            end
            repeat (4) void'(modelQ.pop_front());
        end
    endtask

    // Raises rx_ready at a negedge, holds it, drops it, idles, then tells
    // the model about the byte. Every call is at least 6 cycles long so the
    // resulting strobe has been seen before the next check.
    task automatic applyStimulus(input byte_t b, input int hold, input int low);
        bus.rx_data  = b;
        bus.rx_ready = 1'b1;
        riseCyc      = cyc;
        repeat (hold) @(negedge clk);
        bus.rx_ready = 1'b0;
        repeat (low) @(negedge clk);
        modelFeed(b);
    endtask

    task automatic checkModel(input string tag);
        checkOutput({tag, "_valid_cnt"}, 32'(validCnt), 32'(expValid));
        checkOutput({tag, "_err_cnt"},   32'(errCnt),   32'(expErr));
        checkOutput({tag, "_word"},      32'(bus.word), 32'(modelWord));
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog observed=no finish expected=finish");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        int vBefore;
        int eBefore;
        int r34;
        int lat;
        byte_t lo;
        byte_t hi;
        byte_t ck;
        int kind;
        int h;

        bus.rx_data  = 8'h00;
        bus.rx_ready = 1'b0;
        rst_n        = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        checkOutput("rst_word",       32'(bus.word),       32'h0);
        checkOutput("rst_word_valid", 32'(bus.word_valid), 32'h0);
        checkOutput("rst_chk_err",    32'(bus.chk_err),    32'h0);
        checkOutput("rst_timeout",    32'(bus.timeout),    32'h0);
        checkOutput("rst_busy",       32'(bus.busy),       32'h0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Good frame and its latency from the checksum byte's rx_ready rise
        applyStimulus(8'hA5, 2, 5);
        checkOutput("t1_busy_in_frame", 32'(bus.busy), 32'h1);
        applyStimulus(8'h34, 2, 5);
        applyStimulus(8'h12, 2, 5);
        applyStimulus(8'h46, 2, 5);
        checkOutput("t1_word", 32'(bus.word), 32'h1234);
        checkOutput("t1_latency", 32'(lastValidCyc - riseCyc), 32'd4);
        checkOutput("t1_busy_after", 32'(bus.busy), 32'h0);
        checkModel("t1");

        // Bad checksum keeps the previous word
        applyStimulus(8'hA5, 2, 5);
        applyStimulus(8'h34, 2, 5);
        applyStimulus(8'h12, 2, 5);
        applyStimulus(8'h47, 2, 5);
        checkOutput("t2_word", 32'(bus.word), 32'h1234);
        checkOutput("t2_err_cnt_abs", 32'(errCnt), 32'd1);
        checkModel("t2");

        // Junk before sync, second sync byte is data
        applyStimulus(8'h00, 2, 5);
        applyStimulus(8'h7F, 2, 5);
        applyStimulus(8'hA5, 2, 5);
        applyStimulus(8'hA5, 2, 5);
        applyStimulus(8'hFF, 2, 5);
        applyStimulus(8'hA4, 2, 5);
        checkOutput("t3_word", 32'(bus.word), 32'hFFA5);
        checkModel("t3");

        // Inter-byte timeout, then recovery
        applyStimulus(8'hA5, 2, 5);
        applyStimulus(8'h34, 2, 5);
        r34 = riseCyc;
        checkOutput("t4_busy_before_to", 32'(bus.busy), 32'h1);
        repeat (TO_CYC + 10) @(negedge clk);
        modelQ.delete();
        checkOutput("t4_timeout_cnt", 32'(toCnt), 32'd1);
        lat = lastToCyc - r34;
        checkOutput("t4_timeout_window", 32'(lat >= TO_CYC && lat <= TO_CYC + 6), 32'd1);
        checkOutput("t4_busy_after_to", 32'(bus.busy), 32'h0);
        checkOutput("t4_word_kept", 32'(bus.word), 32'hFFA5);
        applyStimulus(8'hA5, 2, 5);
        applyStimulus(8'h01, 2, 5);
        applyStimulus(8'h02, 2, 5);
        applyStimulus(8'h03, 2, 5);
        checkOutput("t4_word_recover", 32'(bus.word), 32'h0201);
        checkModel("t4");

        // Reset mid-frame
        applyStimulus(8'hA5, 2, 5);
        applyStimulus(8'h34, 2, 5);
        checkOutput("t5_busy_pre_rst", 32'(bus.busy), 32'h1);
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("t5_rst_word", 32'(bus.word), 32'h0);
        checkOutput("t5_rst_busy", 32'(bus.busy), 32'h0);
        modelQ.delete();
        modelWord = 16'h0000;
        @(negedge clk);
        rst_n = 1'b1;
        vBefore = validCnt;
        eBefore = errCnt;
        applyStimulus(8'h12, 2, 5);
        applyStimulus(8'h46, 2, 5);
        checkOutput("t5_no_valid", 32'(validCnt - vBefore), 32'd0);
        checkOutput("t5_no_err",   32'(errCnt - eBefore),   32'd0);
        checkOutput("t5_busy_after", 32'(bus.busy), 32'h0);
        checkModel("t5");

        // rx_ready held high for 20 cycles per byte
        vBefore = validCnt;
        applyStimulus(8'hA5, 20, 6);
        applyStimulus(8'hFF, 20, 6);
        applyStimulus(8'hFF, 20, 6);
        applyStimulus(8'hFE, 20, 6);
        checkOutput("t6_word", 32'(bus.word), 32'hFFFF);
        checkOutput("t6_valid_once", 32'(validCnt - vBefore), 32'd1);
        checkModel("t6");

        // Random stream of junk, good frames and corrupted frames
        for (int i = 0; i < 40; i++) begin
            kind = int'($urandom_range(0, 3));
            h    = int'($urandom_range(1, 3));
            if (kind == 0) begin
                applyStimulus(byte_t'($urandom_range(0, 255)), h, 7 - h);
                checkModel("rnd_junk");
            end else begin
                lo = byte_t'($urandom_range(0, 255));
                hi = byte_t'($urandom_range(0, 255));
                if (kind == 3) begin
                    ck = byte_t'((int'(lo) + int'(hi) + int'($urandom_range(1, 255))) % 256);
                end else begin
                    ck = byte_t'((int'(lo) + int'(hi)) % 256);
                end
                applyStimulus(SYNC, h, 7 - h);
                applyStimulus(lo, h, 7 - h);
                applyStimulus(hi, h, 7 - h);
                applyStimulus(ck, h, 7 - h);
                checkModel("rnd_frame");
            end
        end

        checkOutput("final_timeout_cnt", 32'(toCnt), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
